// File: rtl/car_direction_fsm.sv
// Car passage direction detector: synchronizes and debounces two beam sensors and
// tracks the blocking order to emit entry (inc), exit (dec) and error (err) pulses.
module car_direction_fsm #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic inc,
    output logic dec,
    output logic err,
    output logic busy
);
    localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, ENT_A, ENT_AB, ENT_B, EXT_B, EXT_BA, EXT_A, ERR
    } state_t;

    logic [1:0]  sync_a, sync_b;
    logic        filt_a, filt_b;
    logic [7:0]  cnt_a, cnt_b;
    logic [15:0] tmo_cnt;
    logic [1:0]  pair;
    logic        inc_next, dec_next, err_next;
    state_t      state, state_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[0], sensor_a};
            sync_b <= {sync_b[0], sensor_b};
        end
    end

    // Counter only runs while the synchronized level disagrees with the filtered one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_a <= 1'b0;
            cnt_a  <= '0;
        end else if (sync_a[1] == filt_a) begin
            cnt_a <= '0;
        end else if (cnt_a == DEB_LAST) begin
            filt_a <= sync_a[1];
            cnt_a  <= '0;
        end else begin
            cnt_a <= cnt_a + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_b <= 1'b0;
            cnt_b  <= '0;
        end else if (sync_b[1] == filt_b) begin
            cnt_b <= '0;
        end else if (cnt_b == DEB_LAST) begin
            filt_b <= sync_b[1];
            cnt_b  <= '0;
        end else begin
            cnt_b <= cnt_b + 8'd1;
        end
    end

    assign pair = {filt_a, filt_b};
    assign busy = (state != IDLE);

    always_comb begin
        state_next = state;
        inc_next   = 1'b0;
        dec_next   = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: case (pair)
                2'b10: state_next = ENT_A;
                2'b01: state_next = EXT_B;
                2'b11: begin state_next = ERR; err_next = 1'b1; end
                default: ;
            endcase
            ENT_A: case (pair)
                2'b11: state_next = ENT_AB;
                2'b00: state_next = IDLE;
                2'b01: begin state_next = ERR; err_next = 1'b1; end
                default: ;
            endcase
            ENT_AB: case (pair)
                2'b01: state_next = ENT_B;
                2'b10: state_next = ENT_A;
                2'b00: begin state_next = ERR; err_next = 1'b1; end
                default: ;
            endcase
            ENT_B: case (pair)
                2'b00: begin state_next = IDLE; inc_next = 1'b1; end
                2'b11: state_next = ENT_AB;
                2'b10: begin state_next = ERR; err_next = 1'b1; end
                default: ;
            endcase
            EXT_B: case (pair)
                2'b11: state_next = EXT_BA;
                2'b00: state_next = IDLE;
                2'b10: begin state_next = ERR; err_next = 1'b1; end
                default: ;
            endcase
            EXT_BA: case (pair)
                2'b10: state_next = EXT_A;
                2'b01: state_next = EXT_B;
                2'b00: begin state_next = ERR; err_next = 1'b1; end
                default: ;
            endcase
            EXT_A: case (pair)
                2'b00: begin state_next = IDLE; dec_next = 1'b1; end
                2'b11: state_next = EXT_BA;
                2'b01: begin state_next = ERR; err_next = 1'b1; end
                default: ;
            endcase
            ERR: if (pair == 2'b00) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Timeout overrides whatever the sensor pair would have done this cycle.
        if (state != IDLE && state != ERR && tmo_cnt == TMO_LAST) begin
            state_next = ERR;
            inc_next   = 1'b0;
            dec_next   = 1'b0;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            inc     <= 1'b0;
            dec     <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_next;
            tmo_cnt <= (state == IDLE || state == ERR) ? '0 : tmo_cnt + 16'd1;
            inc     <= inc_next;
            dec     <= dec_next;
            err     <= err_next;
        end
    end
endmodule

// File: tb/tb_car_direction_fsm.sv
// Bench for car_direction_fsm: two instances (long and short timeout) driven by the same
// sensors, checked every cycle against a path-based passage model.
module tb_car_direction_fsm;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       raw_a = 1'b0;
    logic       raw_b = 1'b0;
    logic [1:0] inc_o, dec_o, err_o, busy_o;

    always #5 clk = ~clk;

    car_direction_fsm #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset_n(reset_n), .sensor_a(raw_a), .sensor_b(raw_b),
        .inc(inc_o[0]), .dec(dec_o[0]), .err(err_o[0]), .busy(busy_o[0])
    );

    car_direction_fsm #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut_t (
        .clk(clk), .reset_n(reset_n), .sensor_a(raw_a), .sensor_b(raw_b),
        .inc(inc_o[1]), .dec(dec_o[1]), .err(err_o[1]), .busy(busy_o[1])
    );

    // A passage is a walk along a fixed path of sensor pairs (a is the MSB).
    int timeout_of[2] = '{1000, 20};
    int ent_path[5]   = '{0, 2, 3, 1, 0};
    int ext_path[5]   = '{0, 1, 3, 2, 0};

    bit m_s1a, m_s2a, m_s1b, m_s2b, m_fa, m_fb;
    bit hist_a[D], hist_b[D];
    int mode[2];   // 0 idle, 1 entering, 2 exiting, 3 error
    int pos[2];
    int start[2];
    bit m_inc[2], m_dec[2], m_err[2];
    int cyc;
    int checks = 0;
    int fails = 0;
    int n_inc[2], n_dec[2], n_err[2];
    int inc_at;
    int c0;

    function automatic int path_at(int m, int i);
        return (m == 1) ? ent_path[i] : ext_path[i];
    endfunction

    function automatic void model_reset();
        m_s1a = 0; m_s2a = 0; m_s1b = 0; m_s2b = 0; m_fa = 0; m_fb = 0;
        for (int i = 0; i < D; i++) begin hist_a[i] = 0; hist_b[i] = 0; end
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; pos[k] = 0; start[k] = 0;
            m_inc[k] = 0; m_dec[k] = 0; m_err[k] = 0;
        end
    endfunction

    function automatic void model_step();
        int p;
        bit da, db;
        cyc++;
        p = (m_fa ? 2 : 0) + (m_fb ? 1 : 0);
        for (int k = 0; k < 2; k++) begin
            m_inc[k] = 0; m_dec[k] = 0; m_err[k] = 0;
            if (mode[k] == 3) begin
                if (p == 0) mode[k] = 0;
            end else if (mode[k] == 0) begin
                if (p == 2)      begin mode[k] = 1; pos[k] = 1; start[k] = cyc; end
                else if (p == 1) begin mode[k] = 2; pos[k] = 1; start[k] = cyc; end
                else if (p == 3) begin mode[k] = 3; m_err[k] = 1; end
            end else if (cyc - start[k] == timeout_of[k]) begin
                mode[k] = 3; m_err[k] = 1;
            end else if (p == path_at(mode[k], pos[k])) begin
            end else if (p == path_at(mode[k], pos[k] + 1)) begin
                pos[k]++;
                if (pos[k] == 4) begin
                    if (mode[k] == 1) m_inc[k] = 1; else m_dec[k] = 1;
                    mode[k] = 0;
                end
            end else if (p == path_at(mode[k], pos[k] - 1)) begin
                pos[k]--;
                if (pos[k] == 0) mode[k] = 0;
            end else begin
                mode[k] = 3; m_err[k] = 1;
            end
        end
        // Filtered level flips once the last D synchronized samples all disagree with it.
        for (int i = D - 1; i > 0; i--) begin hist_a[i] = hist_a[i-1]; hist_b[i] = hist_b[i-1]; end
        hist_a[0] = m_s2a; hist_b[0] = m_s2b;
        da = 1; db = 1;
        for (int i = 0; i < D; i++) begin
            if (hist_a[i] == m_fa) da = 0;
            if (hist_b[i] == m_fb) db = 0;
        end
        if (da) m_fa = ~m_fa;
        if (db) m_fb = ~m_fb;
        m_s2a = m_s1a; m_s1a = raw_a;
        m_s2b = m_s1b; m_s1b = raw_b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("inc[%0d]", k), 32'(inc_o[k]), 32'(m_inc[k]));
            check($sformatf("dec[%0d]", k), 32'(dec_o[k]), 32'(m_dec[k]));
            check($sformatf("err[%0d]", k), 32'(err_o[k]), 32'(m_err[k]));
            check($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(mode[k] != 0));
        end
    endtask

    task automatic tick(input logic a, input logic b);
        raw_a = a;
        raw_b = b;
        @(posedge clk);
        if (reset_n) model_step(); else model_reset();
        #1;
        compare_all();
        for (int k = 0; k < 2; k++) begin
            if (inc_o[k] === 1'b1) n_inc[k]++;
            if (dec_o[k] === 1'b1) n_dec[k]++;
            if (err_o[k] === 1'b1) n_err[k]++;
        end
        if (inc_o[0] === 1'b1) inc_at = cyc;
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        repeat (n) tick(a, b);
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin n_inc[k] = 0; n_dec[k] = 0; n_err[k] = 0; end
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
    endtask

    initial begin
        cyc = 0;
        inc_at = -1;
        model_reset();
        clear_counts();
        hold(0, 0, 3);
        reset_n = 1'b1;
        hold(0, 0, 5);

        // Entry with latency measured from the final raw 00
        clear_counts();
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
        c0 = cyc;
        inc_at = -1;
        hold(0, 0, 12);
        check("entry_inc_count", 32'(n_inc[0]), 32'd1);
        check("entry_dec_count", 32'(n_dec[0]), 32'd0);
        check("entry_err_count", 32'(n_err[0]), 32'd0);
        check("entry_latency", 32'(inc_at - c0), 32'(D + 3));

        // Exit
        clear_counts();
        hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 12);
        check("exit_dec_count", 32'(n_dec[0]), 32'd1);
        check("exit_inc_count", 32'(n_inc[0]), 32'd0);
        check("exit_err_count", 32'(n_err[0]), 32'd0);

        // Back-out and a short glitch
        clear_counts();
        hold(1, 0, 10); hold(0, 0, 12); hold(1, 0, 3); hold(0, 0, 10);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("backout_pulses[%0d]", k), 32'(n_inc[k] + n_dec[k] + n_err[k]), 32'd0);
            check($sformatf("backout_busy[%0d]", k), 32'(busy_o[k]), 32'd0);
        end

        // Illegal 10 -> 01
        clear_counts();
        hold(1, 0, 10); hold(0, 1, 10); hold(0, 0, 3);
        check("illegal_busy_held", 32'(busy_o[0]), 32'd1);
        hold(0, 0, 9);
        check("illegal_err_count", 32'(n_err[0]), 32'd1);
        check("illegal_inc_count", 32'(n_inc[0]), 32'd0);
        check("illegal_busy_end", 32'(busy_o[0]), 32'd0);

        // Timeout on the short-timeout instance
        clear_counts();
        hold(1, 0, 30); hold(0, 0, 12);
        check("timeout_err_count", 32'(n_err[1]), 32'd1);
        check("timeout_inc_count", 32'(n_inc[1]), 32'd0);
        check("timeout_busy_end", 32'(busy_o[1]), 32'd0);
        check("no_timeout_err_count", 32'(n_err[0]), 32'd0);

        // Reset during ENT_AB
        hold(1, 0, 10); hold(1, 1, 10);
        check("mid_busy_before_reset", 32'(busy_o[0]), 32'd1);
        assert_reset();
        hold(1, 1, 3);
        reset_n = 1'b1;
        clear_counts();
        hold(0, 1, 10); hold(0, 0, 12);
        check("post_reset_inc0", 32'(n_inc[0]), 32'd0);
        check("post_reset_inc1", 32'(n_inc[1]), 32'd0);

        // Sensors already blocked at release
        assert_reset();
        hold(1, 1, 3);
        reset_n = 1'b1;
        clear_counts();
        hold(1, 1, 25);
        check("blocked_release_err", 32'(n_err[0]), 32'd1);
        hold(0, 0, 12);
        check("blocked_release_err_end", 32'(n_err[0]), 32'd1);
        check("blocked_release_busy", 32'(busy_o[0]), 32'd0);

        // Random sensor activity against the model
        repeat (300) begin
            logic ra, rb;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            hold(ra, rb, int'($urandom_range(1, 12)));
        end
        hold(0, 0, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/car_direction_fsm.md
CAR_DIRECTION_FSM -- requirements
Module: car_direction_fsm

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronized sensor level must persist before it is accepted; legal range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: maximum cycles a passage may stay in progress; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sensor_a  input  1  outer beam sensor, asynchronous to clk; 1 = beam blocked.
REQ-006 sensor_b  input  1  inner beam sensor, asynchronous to clk; 1 = beam blocked.
REQ-007 inc  output  1  one-cycle pulse per completed entry; drives the occupancy counter's increment input.
REQ-008 dec  output  1  one-cycle pulse per completed exit; drives the occupancy counter's decrement input.
REQ-009 err  output  1  one-cycle pulse on an illegal sensor sequence or timeout.
REQ-010 busy  output  1  high while the FSM is in any state other than IDLE.

Function
REQ-011 Each sensor shall pass through a 2-flop synchronizer, then a per-sensor debouncer.
REQ-012 The debouncer shall hold a filtered level and a counter; the counter clears whenever the synchronized level equals the filtered level.
REQ-013 The filtered level shall take the synchronized value on the edge where the synchronized value has differed for DEBOUNCE_CYCLES consecutive cycles; a shorter glitch shall leave it unchanged.
REQ-014 The FSM shall sample the filtered pair {a,b}; states: IDLE, ENT_A, ENT_AB, ENT_B, EXT_B, EXT_BA, EXT_A, ERR.
REQ-015 IDLE: 10->ENT_A; 01->EXT_B; 11->ERR with err pulse; 00->stay.
REQ-016 ENT_A: 11->ENT_AB; 00->IDLE, no pulse (car backed out); 01->ERR with err.
REQ-017 ENT_AB: 01->ENT_B; 10->ENT_A; 00->ERR with err.
REQ-018 ENT_B: 00->IDLE with inc pulse; 11->ENT_AB; 10->ERR with err.
REQ-019 EXT_B, EXT_BA and EXT_A shall mirror REQ-016..018 with a and b swapped; EXT_A on 00->IDLE with dec pulse.
REQ-020 ERR: leave to IDLE only after the filtered pair is 00; no pulses while in ERR.
REQ-021 inc, dec and err shall be registered, high for exactly one cycle: the cycle after the edge that performs the qualifying transition.
REQ-022 inc and dec shall never be high in the same cycle; at most one of inc/dec/err per cycle.
REQ-023 A 16-bit timeout counter shall clear in IDLE and ERR and increment every cycle otherwise.
REQ-024 When the counter reaches TIMEOUT_CYCLES-1 without returning to IDLE, the FSM shall enter ERR with an err pulse; timeout takes priority over a same-cycle sequence transition.
REQ-025 Raw-to-pulse latency shall be DEBOUNCE_CYCLES+3 edges after the final raw sensor change settles.

Reset
REQ-026 While reset_n is low: synchronizers, filtered levels and counters at 0, FSM in IDLE, inc=dec=err=busy=0.
REQ-027 Reset assertion mid-passage shall abort the passage with no pulse; after release the FSM shall start in IDLE regardless of sensor levels.
REQ-028 If sensors are already 11 at release, the FSM shall reach ERR with one err pulse once filtering completes.

Verification
REQ-029 Entry 00->10->11->01->00, each level held 10 cycles -> exactly one inc pulse, 7 edges after the final 00 (DEBOUNCE_CYCLES=4); dec=err=0 throughout.
REQ-030 Exit 00->01->11->10->00 -> exactly one dec pulse; inc=0.
REQ-031 Back-out 00->10->00, and a 3-cycle glitch on sensor_a -> no pulses, busy returns to 0.
REQ-032 Illegal sequence 10->01 -> one err pulse, busy stays 1 until 00 is held 4 cycles, then IDLE.
REQ-033 Hold 10 for TIMEOUT_CYCLES+10 cycles (TIMEOUT_CYCLES=20) -> one err pulse at timeout; a later 00 returns to IDLE with no inc.
REQ-034 Assert reset_n low during ENT_AB -> all outputs 0 immediately; no inc after release.
